// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN target-network sequencer: layer codes,
// per-layer weight counts and the controller state encoding.
package dqn_pkg;

  localparam logic [1:0] LAYER_L1  = 2'b01;
  localparam logic [1:0] LAYER_L2  = 2'b10;
  localparam logic [1:0] LAYER_OUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SYNC_L1, SYNC_L2, SYNC_OUT, SYNC_DRAIN, EVAL_LOAD, EVAL_WAIT
  } ctrl_state_e;

  // Weights per layer include one bias per node.
  function automatic int N1(input int h1, input int i);
    return h1 * (i + 1);
  endfunction

  function automatic int N2(input int h2, input int h1);
    return h2 * (h1 + 1);
  endfunction

  function automatic int N3(input int o, input int h2);
    return o * (h2 + 1);
  endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Flat layer/address walker over the three weight layers; wraps the address
// at each layer's terminal count and steps to the next layer code.
module weight_addr_gen
  import dqn_pkg::*;
#(
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            advance,
  output logic [LAYER_WIDTH-1:0]          layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] addr,
  output logic                            last
);

  localparam int WCW = WEIGHT_COUNTER_WIDTH;
  localparam logic [WCW-1:0] T1 =
    WCW'(N1(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE) - 1);
  localparam logic [WCW-1:0] T2 =
    WCW'(N2(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1) - 1);
  localparam logic [WCW-1:0] T3 =
    WCW'(N3(NUMBER_OF_OUTPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_2) - 1);
  localparam logic [LAYER_WIDTH-1:0] C_L1  = LAYER_WIDTH'(LAYER_L1);
  localparam logic [LAYER_WIDTH-1:0] C_L2  = LAYER_WIDTH'(LAYER_L2);
  localparam logic [LAYER_WIDTH-1:0] C_OUT = LAYER_WIDTH'(LAYER_OUT);

  logic [LAYER_WIDTH-1:0] layer_q;
  logic [WCW-1:0]         addr_q;
  logic [WCW-1:0]         term;

  always_comb begin
    term = T3;
    if (layer_q == C_L1)      term = T1;
    else if (layer_q == C_L2) term = T2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q <= C_L1;
      addr_q  <= '0;
    end else if (start) begin
      layer_q <= C_L1;
      addr_q  <= '0;
    end else if (advance) begin
      if (addr_q == term) begin
        addr_q  <= '0;
        layer_q <= (layer_q == C_OUT) ? C_L1 : layer_q + 1'b1;
      end else begin
        addr_q  <= addr_q + 1'b1;
      end
    end
  end

  assign layer = layer_q;
  assign addr  = addr_q;
  assign last  = (layer_q == C_OUT) && (addr_q == T3);

endmodule

// File: rtl/target_net_ctrl.sv
// Target Q-network sequencer: copies main-net weights into target_net through
// a two-stage read pipeline, then streams state vectors and returns q_max.
module target_net_ctrl
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int DATA_COUNTER_WIDTH            = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_sync_start,
  input  logic                                       i_eval_start,
  input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_state,
  output logic                                       o_src_rd_en,
  output logic [LAYER_WIDTH-1:0]                     o_src_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_src_addr,
  input  logic [DATA_WIDTH-1:0]                      i_src_data,
  output logic                                       o_weight_valid,
  output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_weight_addr,
  output logic [DATA_WIDTH-1:0]                      o_weight,
  output logic                                       o_rw_weight_select,
  output logic                                       o_data_valid,
  output logic [DATA_COUNTER_WIDTH-1:0]              o_data_addr,
  output logic [DATA_WIDTH-1:0]                      o_data,
  input  logic                                       i_q_max_valid,
  input  logic [DATA_WIDTH-1:0]                      i_q_max,
  output logic                                       o_q_max_valid,
  output logic [DATA_WIDTH-1:0]                      o_q_max,
  output logic                                       o_busy,
  output logic                                       o_weights_loaded,
  output logic                                       o_sync_done
);

  localparam int LW  = LAYER_WIDTH;
  localparam int WCW = WEIGHT_COUNTER_WIDTH;
  localparam int DCW = DATA_COUNTER_WIDTH;
  localparam logic [WCW-1:0] L1_LAST =
    WCW'(N1(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE) - 1);
  localparam logic [WCW-1:0] L2_LAST =
    WCW'(N2(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1) - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(NUMBER_OF_INPUT_NODE - 1);

  ctrl_state_e                              state_q;
  logic [1:0]                               drain_cnt_q;
  logic [DCW-1:0]                           data_cnt_q;
  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] state_vec_q;
  logic                                     busy_q, loaded_q, done_q;
  logic                                     rd_en_q, p1_vld_q, wv_q;
  logic [LW-1:0]                            rd_layer_q, p1_layer_q, w_layer_q;
  logic [WCW-1:0]                           rd_addr_q, p1_addr_q, w_addr_q;
  logic [DATA_WIDTH-1:0]                    w_data_q, d_data_q, q_q;
  logic                                     dv_q, qv_q;
  logic [DCW-1:0]                           d_addr_q;

  logic           gen_start, gen_adv, gen_last, acc_sync, acc_eval;
  logic [LW-1:0]  gen_layer;
  logic [WCW-1:0] gen_addr;

  // busy_q lags state by one cycle, so a start in that cycle is still refused.
  assign acc_sync  = (state_q == IDLE) && !busy_q && i_sync_start;
  assign acc_eval  = (state_q == IDLE) && !busy_q && i_eval_start && loaded_q;
  assign gen_start = acc_sync;
  assign gen_adv   = (state_q == SYNC_L1) || (state_q == SYNC_L2) || (state_q == SYNC_OUT);

  weight_addr_gen #(
    .LAYER_WIDTH                  (LAYER_WIDTH),
    .WEIGHT_COUNTER_WIDTH         (WEIGHT_COUNTER_WIDTH),
    .NUMBER_OF_INPUT_NODE         (NUMBER_OF_INPUT_NODE),
    .NUMBER_OF_HIDDEN_NODE_LAYER_1(NUMBER_OF_HIDDEN_NODE_LAYER_1),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(NUMBER_OF_HIDDEN_NODE_LAYER_2),
    .NUMBER_OF_OUTPUT_NODE        (NUMBER_OF_OUTPUT_NODE)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (gen_start),
    .advance(gen_adv),
    .layer  (gen_layer),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      data_cnt_q  <= '0;
      state_vec_q <= '0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_layer_q  <= '0;
      rd_addr_q   <= '0;
      p1_vld_q    <= 1'b0;
      p1_layer_q  <= '0;
      p1_addr_q   <= '0;
      wv_q        <= 1'b0;
      w_layer_q   <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      dv_q        <= 1'b0;
      d_addr_q    <= '0;
      d_data_q    <= '0;
      qv_q        <= 1'b0;
      q_q         <= '0;
    end else begin
      busy_q  <= (state_q != IDLE);
      done_q  <= 1'b0;
      qv_q    <= 1'b0;
      rd_en_q <= 1'b0;
      dv_q    <= 1'b0;
      // RAM returns data one cycle after the strobe; tags follow two stages.
      p1_vld_q <= rd_en_q;
      wv_q     <= p1_vld_q;
      if (rd_en_q) begin
        p1_layer_q <= rd_layer_q;
        p1_addr_q  <= rd_addr_q;
      end
      if (p1_vld_q) begin
        w_layer_q <= p1_layer_q;
        w_addr_q  <= p1_addr_q;
        w_data_q  <= i_src_data;
      end
      case (state_q)
        IDLE: begin
          if (acc_sync) begin
            state_q  <= SYNC_L1;
            loaded_q <= 1'b0;
          end else if (acc_eval) begin
            state_q     <= EVAL_LOAD;
            state_vec_q <= i_state;
            data_cnt_q  <= '0;
          end
        end
        SYNC_L1, SYNC_L2, SYNC_OUT: begin
          rd_en_q    <= 1'b1;
          rd_layer_q <= gen_layer;
          rd_addr_q  <= gen_addr;
          if (state_q == SYNC_L1 && gen_addr == L1_LAST) state_q <= SYNC_L2;
          if (state_q == SYNC_L2 && gen_addr == L2_LAST) state_q <= SYNC_OUT;
          if (state_q == SYNC_OUT && gen_last) begin
            state_q     <= SYNC_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        SYNC_DRAIN: begin
          if (drain_cnt_q == 2'd2) begin
            done_q   <= 1'b1;
            loaded_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        EVAL_LOAD: begin
          dv_q       <= 1'b1;
          d_addr_q   <= data_cnt_q;
          d_data_q   <= state_vec_q[32'(data_cnt_q)*DATA_WIDTH +: DATA_WIDTH];
          data_cnt_q <= data_cnt_q + 1'b1;
          if (data_cnt_q == D_LAST) state_q <= EVAL_WAIT;
        end
        EVAL_WAIT: begin
          if (i_q_max_valid) begin
            q_q     <= i_q_max;
            qv_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_src_rd_en        = rd_en_q;
  assign o_src_layer        = rd_layer_q;
  assign o_src_addr         = rd_addr_q;
  assign o_weight_valid     = wv_q;
  assign o_weight_layer     = w_layer_q;
  assign o_weight_addr      = w_addr_q;
  assign o_weight           = w_data_q;
  assign o_rw_weight_select = 1'b0;
  assign o_data_valid       = dv_q;
  assign o_data_addr        = d_addr_q;
  assign o_data             = d_data_q;
  assign o_q_max_valid      = qv_q;
  assign o_q_max            = q_q;
  assign o_busy             = busy_q;
  assign o_weights_loaded   = loaded_q;
  assign o_sync_done        = done_q;

endmodule

// File: doc/target_net_ctrl.md
# target_net_ctrl

Sequencer for the target Q-network. On request it copies a full weight set from the main-network weight store into `target_net`, layer by layer, over the target net's weight-write port. It then runs evaluations by streaming a state vector into the data port and returning the `o_q_max` result. It sits between the DQN top-level training FSM, the main-net weight RAM and `target_net`.

## Interface

Parameters:
- `DATA_WIDTH`, 32, word width (IEEE-754 single)
- `LAYER_WIDTH`, 2, layer code width
- `NUMBER_OF_INPUT_NODE`, 2, state vector length
- `NUMBER_OF_HIDDEN_NODE_LAYER_1`, 32, hidden-layer-1 nodes
- `NUMBER_OF_HIDDEN_NODE_LAYER_2`, 32, hidden-layer-2 nodes
- `NUMBER_OF_OUTPUT_NODE`, 3, action count
- `WEIGHT_COUNTER_WIDTH`, 11, weight address width
- `DATA_COUNTER_WIDTH`, `$clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)`, data address width

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous reset, active-low
- `i_sync_start` in 1: pulse; copy all weights main -> target
- `i_eval_start` in 1: pulse; evaluate `i_state`
- `i_state` in `NUMBER_OF_INPUT_NODE*DATA_WIDTH`: state vector; word k in bits `[k*DATA_WIDTH +: DATA_WIDTH]`; sampled on accepted `i_eval_start`
- `o_src_rd_en` out 1: weight-RAM read strobe
- `o_src_layer` out `LAYER_WIDTH`: read layer code
- `o_src_addr` out `WEIGHT_COUNTER_WIDTH`: read address
- `i_src_data` in `DATA_WIDTH`: read data, valid the cycle after `o_src_rd_en`
- `o_weight_valid`, `o_weight_layer`, `o_weight_addr`, `o_weight` out 1/`LAYER_WIDTH`/`WEIGHT_COUNTER_WIDTH`/`DATA_WIDTH`: to `target_net` weight port
- `o_rw_weight_select` out 1: constant 0 (write) to `target_net`
- `o_data_valid`, `o_data_addr`, `o_data` out 1/`DATA_COUNTER_WIDTH`/`DATA_WIDTH`: to `target_net` data port
- `i_q_max_valid`, `i_q_max` in 1/`DATA_WIDTH`: from `target_net`
- `o_q_max_valid`, `o_q_max` out 1/`DATA_WIDTH`: evaluation result
- `o_busy` out 1: state is not IDLE
- `o_weights_loaded` out 1: a full sync has completed since reset
- `o_sync_done` out 1: one-cycle pulse at end of sync

## Operation

- Layer codes: L1 = 2'b01, L2 = 2'b10, OUT = 2'b11. Per-layer counts:
  - `N1 = H1*(I+1)`, 96 at defaults
  - `N2 = H2*(H1+1)`, 1056
  - `N3 = O*(H2+1)`, 99
  - Total 1251.
- Addresses run 0..N-1 per layer, node-major with the bias last: `addr = node*(fan_in+1)+k`. This is a flat counter.
- FSM states: IDLE, SYNC_L1, SYNC_L2, SYNC_OUT, SYNC_DRAIN, EVAL_LOAD, EVAL_WAIT.
- IDLE:
  - `i_sync_start` goes to SYNC_L1.
  - Otherwise, `i_eval_start` with `o_weights_loaded` = 1 goes to EVAL_LOAD and latches `i_state`.
  - If both arrive in the same cycle, sync wins and the eval request is dropped.
  - Eval while not loaded is ignored.
- SYNC_Lx:
  - One read per cycle, no bubbles.
  - The layer/address counter wraps to 0 and advances the layer after address N-1.
  - After OUT address N3-1, go to SYNC_DRAIN.
- SYNC_DRAIN: 2 cycles, then `o_sync_done` pulses, `o_weights_loaded` sets, and the FSM returns to IDLE.
- EVAL_LOAD:
  - `o_data_valid` is high for I consecutive cycles.
  - `o_data_addr` runs 0..I-1 and `o_data` carries the latched words.
  - Then go to EVAL_WAIT.
- EVAL_WAIT: on `i_q_max_valid`, register `i_q_max` to `o_q_max`, pulse `o_q_max_valid`, and return to IDLE.
- `i_q_max_valid` outside EVAL_WAIT is ignored.
- Starts while `o_busy` are ignored (no queueing).
- A new sync clears `o_weights_loaded` at entry to SYNC_L1.

## Timing

- All outputs are registered.
- Reset value is 0 for every output.
- Reset mid-operation:
  - The FSM goes to IDLE.
  - `o_weights_loaded` clears.
  - A partially written target net is treated as invalid.
- Read pipeline: `o_src_rd_en` at cycle t, `i_src_data` sampled at t+1, `o_weight_valid` with matching layer/address/data at t+2.
- The read layer/address is delayed 2 stages to form `o_weight_layer` and `o_weight_addr`.
- Sync start to first `o_weight_valid`:
  - `i_sync_start` sampled at edge 0.
  - First read at cycle 1.
  - First write valid at cycle 3.
- The last write is at cycle 1253.
- `o_sync_done` is at cycle 1254, with `o_busy` low from cycle 1255.
- Eval: `i_eval_start` at edge 0 gives data beats at cycles 1..I.
- `o_q_max_valid` asserts exactly 1 cycle after `i_q_max_valid`.

## Structure

- Shared package `dqn_pkg`:
  - Layer-code constants.
  - Count functions `N1`, `N2`, `N3` of the node parameters.
  - FSM state enum.
- Sub-module `weight_addr_gen`:
  - Inputs: start, advance.
  - Outputs: layer, addr, last.
  - Flat counter with per-layer terminal count and layer step.
- The controller instantiates `weight_addr_gen` once and holds the FSM, the read pipeline, the state latch and the result register.

## Test plan

- Sync with a RAM model holding `data = {layer, addr}`:
  - Exactly 1251 `o_weight_valid` beats.
  - Layer 01 addr 0..95, then 10 addr 0..1055, then 11 addr 0..98, contiguous, data matching.
  - `o_sync_done` 1253 cycles after the first read.
- Eval after sync with `i_state` = {3FA00000, BFC00000}:
  - Addr 0 carries BFC00000, addr 1 carries 3FA00000, on consecutive cycles.
  - Model returns `i_q_max` = 40490FDB.
  - `o_q_max` = 40490FDB with a 1-cycle pulse.
- Eval before any sync: no `o_data_valid`, `o_busy` stays 0, `o_q_max_valid` never asserts.
- `i_sync_start` and `i_eval_start` in the same cycle: sync runs and no data beats occur.
- `i_eval_start` during sync: ignored, and the write count is still 1251.
- `rst_n` low at write 500: all outputs 0, `o_weights_loaded` = 0. A new sync then restarts at layer 01 addr 0.
